// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
// Package  : float_pkg
// Purpose  : Shared fp32 field widths, packed layout and sequencer states.
// Revision : 1.0 - initial release
// ============================================================================
package float_pkg;

  localparam int         FRAC_W  = 23;
  localparam int         EXP_W   = 8;
  localparam int         MANT_W  = 25;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ALIGN   = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_NORM    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage : float_pkg
`default_nettype wire

// File: rtl/fp32_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fp32_unpack
// Purpose  : Splits an fp32 word into sign, exponent and a 25-bit mantissa
//            {2'b01,frac}; exp==0 is flagged as zero and its mantissa cleared.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_unpack
  import float_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [MANT_W-1:0] mant_o,
  output logic              zero_o
);

  fp32_t op;

  assign op     = op_i;
  assign zero_o = (op.exp == '0);
  assign sign_o = op.sign;
  assign exp_o  = op.exp;
  assign mant_o = zero_o ? '0 : {2'b01, op.frac};

endmodule : fp32_unpack
`default_nettype wire

// File: rtl/seq_float_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : seq_float_subtractor
// Purpose  : Multi-cycle fp32 subtractor (out = in_a - in_b) with one-bit-per-
//            cycle alignment and normalisation behind valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module seq_float_subtractor
  import float_pkg::*;
#(
  parameter int ALIGN_CAP = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  localparam int               CNT_W   = $clog2(ALIGN_CAP + 1);
  localparam logic [8:0]       CAP_9   = 9'(ALIGN_CAP);
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(ALIGN_CAP);

  logic              a_sign, b_sign, a_zero, b_zero;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [MANT_W-1:0] a_mant, b_mant;

  fp32_unpack u_unpack_a (
    .op_i   (in_a),
    .sign_o (a_sign),
    .exp_o  (a_exp),
    .mant_o (a_mant),
    .zero_o (a_zero)
  );

  fp32_unpack u_unpack_b (
    .op_i   (in_b),
    .sign_o (b_sign),
    .exp_o  (b_exp),
    .mant_o (b_mant),
    .zero_o (b_zero)
  );

  logic [2:0]         state_q, state_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [MANT_W-1:0]  ma_q, ma_d;
  logic [MANT_W-1:0]  mb_q, mb_d;
  logic               shift_b_q, shift_b_d;
  logic signed [8:0]  exp_q, exp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MANT_W-1:0]  sum_q, sum_d;
  logic               sign_q, sign_d;
  logic [31:0]        out_q, out_d;
  logic               out_valid_q, out_valid_d;

  logic               a_ge_b;
  logic [EXP_W-1:0]   exp_diff;
  logic [CNT_W-1:0]   cnt_init;
  logic signed [8:0]  exp_inc;
  logic [31:0]        inf_word;

  assign a_ge_b   = (a_exp >= b_exp);
  assign exp_diff = a_ge_b ? (a_exp - b_exp) : (b_exp - a_exp);
  assign cnt_init = ({1'b0, exp_diff} > CAP_9) ? CAP_CNT : CNT_W'(exp_diff);
  assign exp_inc  = exp_q + 9'sd1;
  assign inf_word = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};

  always_comb begin
    state_d     = state_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    shift_b_d   = shift_b_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    sign_d      = sign_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_a_d  = a_sign;
          sign_b_d  = ~b_sign;
          ma_d      = a_zero ? '0 : a_mant;
          mb_d      = b_zero ? '0 : b_mant;
          shift_b_d = a_ge_b;
          exp_d     = $signed({1'b0, (a_ge_b ? a_exp : b_exp)});
          cnt_d     = cnt_init;
          state_d   = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        if (cnt_q == '0) begin
          state_d = ST_COMPUTE;
        end else begin
          if (shift_b_q) mb_d = mb_q >> 1;
          else           ma_d = ma_q >> 1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_COMPUTE: begin
        if (sign_a_q == sign_b_q) begin
          sum_d  = ma_q + mb_q;
          sign_d = sign_a_q;
        end else if (ma_q >= mb_q) begin
          sum_d  = ma_q - mb_q;
          sign_d = sign_a_q;
        end else begin
          sum_d  = mb_q - ma_q;
          sign_d = sign_b_q;
        end
        state_d = ST_NORM;
      end

      ST_NORM: begin
        // The result word is formed on the edge that leaves NORM, so the
        // final right shift / exponent bump never needs its own cycle.
        if (sum_q == '0) begin
          out_d       = 32'h0000_0000;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (sum_q[24]) begin
          out_d       = (exp_q >= 9'sd254) ? inf_word
                                           : {sign_q, exp_inc[7:0], sum_q[23:1]};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (sum_q[23]) begin
          out_d       = (exp_q >= 9'sd255) ? inf_word
                                           : {sign_q, exp_q[7:0], sum_q[22:0]};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (exp_q <= 9'sd1) begin
          out_d       = 32'h0000_0000;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - 9'sd1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      shift_b_q   <= 1'b0;
      exp_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sign_q      <= 1'b0;
      out_q       <= 32'h0000_0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      shift_b_q   <= shift_b_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sign_q      <= sign_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule : seq_float_subtractor
`default_nettype wire

// File: tb/tb_seq_float_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_float_subtractor
// Purpose  : Scoreboard bench for seq_float_subtractor: directed and random
//            operand pairs checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_float_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  seq_float_subtractor #(.ALIGN_CAP(25)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          rdy_rand   = 1'b0;
  logic        rdy_forced = 1'b1;
  bit          mon_pv;
  bit          mon_phs;
  logic [31:0] mon_pout;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: real-valued subtraction on integer mantissas, then normalise.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    int     ea, eb, e, d, k;
    longint ma, mb, s, mag;
    bit     sg, flushed;
    logic [7:0] e8;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 64'd0 : (64'h80_0000 | longint'(a[22:0]));
    mb = (eb == 0) ? 64'd0 : (64'h80_0000 | longint'(b[22:0]));
    d  = (ea > eb) ? ea - eb : eb - ea;
    if (d > 25) d = 25;
    if (ea >= eb) begin mb = mb >> d; e = ea; end
    else          begin ma = ma >> d; e = eb; end
    s  = (a[31] ? -ma : ma) + (b[31] ? mb : -mb);
    k  = 0;
    flushed = 1'b0;
    if (s == 0) begin
      res = 32'h0;
      lat = d + 3;
      return;
    end
    sg  = (s < 0);
    mag = sg ? -s : s;
    if (mag >= 64'h100_0000) begin
      mag = mag >> 1;
      e   = e + 1;
    end
    while (mag < 64'h80_0000) begin
      mag = mag << 1;
      e   = e - 1;
      k   = k + 1;
      if (e <= 0) begin flushed = 1'b1; break; end
    end
    e8 = e[7:0];
    if (flushed)       res = 32'h0;
    else if (e >= 255) res = {sg, 8'hFF, 23'h0};
    else               res = {sg, e8, mag[22:0]};
    lat = flushed ? -1 : d + k + 3;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expv, input int lat, input bit track);
    int waited = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    if (track) sb_q.push_back('{val: expv, lat: lat, acc: cyc});
  endtask

  task automatic drain();
    int i = 0;
    while ((sb_q.size() != 0 || out_valid) && i < 400) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (sb_q.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL drain_timeout: pending=%0d out_valid=%b required 0/0", sb_q.size(), out_valid);
    end
  endtask

  task automatic gen(output logic [31:0] a, output logic [31:0] b);
    int sel;
    a   = $urandom;
    b   = $urandom;
    sel = int'($urandom_range(0, 5));
    case (sel)
      1: b[30:23] = a[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
      2: b = ($urandom_range(0, 1) == 1) ? a : (a ^ 32'h8000_0000);
      3: if ($urandom_range(0, 1) == 1) a[30:23] = 8'h00; else b[30:23] = 8'h00;
      4: begin
        a[30:23] = 8'(253 + $urandom_range(0, 2));
        b[30:23] = 8'(253 + $urandom_range(0, 2));
      end
      5: begin
        a[30:23] = 8'($urandom_range(1, 3));
        b = a ^ {9'b0, 23'($urandom_range(1, 4095))};
      end
      default: ;
    endcase
  endtask

  initial begin : ready_gen
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_forced;
    end
  end

  initial begin : monitor
    mon_pv   = 1'b0;
    mon_phs  = 1'b0;
    mon_pout = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_pv  = 1'b0;
        mon_phs = 1'b0;
      end else begin
        if (mon_phs) begin
          chk("valid_drop_after_hs", {31'b0, out_valid}, 32'h0);
          chk("in_ready_after_hs", {31'b0, in_ready}, 32'h1);
        end
        if (out_valid) begin
          chk("in_ready_while_busy", {31'b0, in_ready}, 32'h0);
          if (mon_pv && !mon_phs) chk("out_hold", out, mon_pout);
          if (!mon_pv) begin
            if (sb_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_output: actual=%h required none", out);
            end else if (sb_q[0].lat >= 0) begin
              chk_int("latency", cyc - sb_q[0].acc, sb_q[0].lat);
            end
          end
          if (out_ready) begin
            if (sb_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_handshake: actual=%h required none", out);
            end else begin
              mon_e = sb_q.pop_front();
              chk("result", out, mon_e.val);
            end
          end
        end
        mon_pv   = out_valid;
        mon_phs  = out_valid && out_ready;
        mon_pout = out;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] a, b, r;
    int          lat;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_out", out, 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 1'b1);
    send(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3, 1'b1);
    send(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 3, 1'b1);
    send(32'h3F80_0000, 32'h3FC0_0000, 32'hBF00_0000, 4, 1'b1);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    rdy_forced = 1'b0;
    @(posedge clk);
    #1;
    send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 1'b1);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk("bp_valid_seen", {31'b0, out_valid}, 32'h1);
    repeat (5) @(negedge clk);
    chk("bp_out_stable", out, 32'h4000_0000);
    rdy_forced = 1'b1;
    drain();

    // Reset in the middle of a 20-shift alignment.
    @(posedge clk);
    #1;
    send(32'h3F80_0000, 32'h3580_0000, 32'h0, -1, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midreset_out", out, 32'h0);
    chk("midreset_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'h1);
    repeat (80) @(negedge clk);

    rdy_rand = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 250; n++) begin
      gen(a, b);
      model(a, b, r, lat);
      send(a, b, r, lat, 1'b1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_float_subtractor
`default_nettype wire
